// File: rtl/hazard_tag_pipe_pkg.sv
// Shared types for the destination-tag pipeline: tag layout, NOP tag,
// and the per-cycle priority select used by the tag stages.
package hazard_tag_pipe_pkg;

  localparam int TAG_REGW = 5;

  typedef struct packed {
    logic [TAG_REGW-1:0] rd;
    logic                wb;
    logic                memrd;
  } tag_t;

  localparam tag_t NOP_TAG = '{rd: '0, wb: 1'b0, memrd: 1'b0};

  // Winning condition for the cycle, highest priority first: HOLD, FLUSH, LU
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLDST  = 2'd1,
    FLUSHST = 2'd2,
    LUST    = 2'd3
  } sel_e;

  // A write to x0 is architecturally a no-op, so its tag never claims a write
  function automatic tag_t sanitize_tag(input tag_t t);
    tag_t r;
    r    = t;
    r.wb = t.wb & (t.rd != '0);
    return r;
  endfunction

endpackage

// File: rtl/hazard_tag_pipe_tag_stage.sv
// One pipeline tag register with hold (freeze), clear (load NOP) and
// load controls. Hold beats clear beats load.
module tag_stage
  import hazard_tag_pipe_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic clear,
  input  tag_t d,
  output tag_t q
);

  // Tag register: freeze, insert a NOP, or capture the upstream tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= NOP_TAG;
    end else if (hold) begin
      q <= q;
    end else if (clear) begin
      q <= NOP_TAG;
    end else begin
      q <= sanitize_tag(d);
    end
  end

endmodule

// File: rtl/hazard_tag_pipe.sv
// Destination-tag pipeline for operand forwarding (ID/EX, EX/MEM, MEM/WB)
// with load-use hazard detection producing a one-cycle stall and bubble.
// Optional feature macro: HAZ_STATS_EN adds the STALLCNT load-use counter.
module hazard_tag_pipe #(
  parameter int REGW = hazard_tag_pipe_pkg::TAG_REGW
`ifdef HAZ_STATS_EN
  , parameter int STATW = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ID_VALID,
  input  logic [REGW-1:0] ID_RD,
  input  logic            ID_WB,
  input  logic            ID_MEMRD,
  input  logic [REGW-1:0] ID_RS1,
  input  logic [REGW-1:0] ID_RS2,
  input  logic            ID_USE1,
  input  logic            ID_USE2,
  input  logic            FLUSH,
  input  logic            HOLD,
  output logic            STALL,
  output logic            BUBBLE,
  output logic            EXMEMWB,
  output logic [REGW-1:0] EXMEMRD,
  output logic            MEMWB,
  output logic [REGW-1:0] MEMWBRD,
  output logic [REGW-1:0] IDEXRD
`ifdef HAZ_STATS_EN
  , output logic [STATW-1:0] STALLCNT
`endif
);

  import hazard_tag_pipe_pkg::*;

  tag_t id_tag_p0;
  tag_t idex_p1;
  tag_t exmem_d_p1;
  tag_t exmem_p2;
  tag_t memwb_d_p2;
  tag_t memwb_p3;
  logic lu;
  sel_e sel;
  logic idex_clear;
  logic stage_hold;

  // ID stage: build the incoming tag; an empty ID slot enters as a NOP
  always_comb begin
    id_tag_p0 = NOP_TAG;
    if (ID_VALID) begin
      id_tag_p0.rd    = ID_RD;
      id_tag_p0.wb    = ID_WB;
      id_tag_p0.memrd = ID_MEMRD;
    end
  end

  // Load-use detect: a load in EX whose result the ID instruction reads
  // cannot be forwarded in time
  always_comb begin
    lu = 1'b0;
    if (idex_p1.memrd && idex_p1.wb && (idex_p1.rd != '0) && ID_VALID) begin
      lu = (ID_USE1 && (ID_RS1 == idex_p1.rd)) ||
           (ID_USE2 && (ID_RS2 == idex_p1.rd));
    end
  end

  // Priority select and pipeline controls: HOLD > FLUSH > LU > normal flow
  always_comb begin
    sel        = RUN;
    STALL      = 1'b0;
    BUBBLE     = 1'b0;
    idex_clear = 1'b0;
    stage_hold = 1'b0;
    if (HOLD) begin
      sel = HOLDST;
    end else if (FLUSH) begin
      sel = FLUSHST;
    end else if (lu) begin
      sel = LUST;
    end
    case (sel)
      HOLDST: begin
        STALL      = 1'b1;
        stage_hold = 1'b1;
      end
      FLUSHST: begin
        BUBBLE     = 1'b1;
        idex_clear = 1'b1;
      end
      LUST: begin
        STALL      = 1'b1;
        BUBBLE     = 1'b1;
        idex_clear = 1'b1;
      end
      default: begin
        STALL = 1'b0;
      end
    endcase
  end

  // ID/EX boundary
  tag_stage u_idex (
    .clk   (clk),
    .rst   (rst),
    .hold  (stage_hold),
    .clear (idex_clear),
    .d     (id_tag_p0),
    .q     (idex_p1)
  );

  // EX/MEM boundary: the load flag is only needed in EX
  assign exmem_d_p1 = '{rd: idex_p1.rd, wb: idex_p1.wb, memrd: 1'b0};

  tag_stage u_exmem (
    .clk   (clk),
    .rst   (rst),
    .hold  (stage_hold),
    .clear (1'b0),
    .d     (exmem_d_p1),
    .q     (exmem_p2)
  );

  // MEM/WB boundary
  assign memwb_d_p2 = '{rd: exmem_p2.rd, wb: exmem_p2.wb, memrd: 1'b0};

  tag_stage u_memwb (
    .clk   (clk),
    .rst   (rst),
    .hold  (stage_hold),
    .clear (1'b0),
    .d     (memwb_d_p2),
    .q     (memwb_p3)
  );

  logic unused_memrd;
  assign unused_memrd = &{1'b0, exmem_p2.memrd, memwb_p3.memrd};

  assign IDEXRD  = idex_p1.rd;
  assign EXMEMWB = exmem_p2.wb;
  assign EXMEMRD = exmem_p2.rd;
  assign MEMWB   = memwb_p3.wb;
  assign MEMWBRD = memwb_p3.rd;

`ifdef HAZ_STATS_EN
  logic [STATW-1:0] stallcnt_q;

  // Count cycles where the load-use stall actually wins; wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallcnt_q <= '0;
    end else if (sel == LUST) begin
      stallcnt_q <= stallcnt_q + 1'b1;
    end
  end

  assign STALLCNT = stallcnt_q;
`endif

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Self-checking bench for hazard_tag_pipe: directed vector table, hand
// sequences for multi-cycle corners, and randomized traffic against a
// behavioural model of the tag pipeline.
module tb_hazard_tag_pipe;

  localparam int RW = 5;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [RW-1:0] id_rd;
  logic          id_wb;
  logic          id_memrd;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_use1;
  logic          id_use2;
  logic          flush;
  logic          hold;
  logic          stall;
  logic          bubble;
  logic          exmemwb;
  logic [RW-1:0] exmemrd;
  logic          memwb;
  logic [RW-1:0] memwbrd;
  logic [RW-1:0] idexrd;
`ifdef HAZ_STATS_EN
  logic [31:0]   stallcnt;
  int            m_cnt;
`endif

  int checks = 0;
  int errors = 0;

  hazard_tag_pipe #(.REGW(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .ID_VALID (id_valid),
    .ID_RD    (id_rd),
    .ID_WB    (id_wb),
    .ID_MEMRD (id_memrd),
    .ID_RS1   (id_rs1),
    .ID_RS2   (id_rs2),
    .ID_USE1  (id_use1),
    .ID_USE2  (id_use2),
    .FLUSH    (flush),
    .HOLD     (hold),
    .STALL    (stall),
    .BUBBLE   (bubble),
    .EXMEMWB  (exmemwb),
    .EXMEMRD  (exmemrd),
    .MEMWB    (memwb),
    .MEMWBRD  (memwbrd),
    .IDEXRD   (idexrd)
`ifdef HAZ_STATS_EN
    , .STALLCNT (stallcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          valid;
    logic [RW-1:0] rd;
    logic          wb;
    logic          memrd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic          use1;
    logic          use2;
    logic          flush;
    logic          hold;
    logic          exp_stall;
    logic          exp_bubble;
  } vec_t;

  // Behavioural model: pipe[0]=ID/EX, pipe[1]=EX/MEM, pipe[2]=MEM/WB
  typedef struct {
    int rd;
    bit wb;
    bit ld;
  } mtag_t;

  mtag_t pipe[3];

  function automatic vec_t mk(input bit v, input int rd, input bit wb, input bit ld,
                              input int rs1, input bit u1, input int rs2, input bit u2,
                              input bit fl, input bit ho, input bit es, input bit eb);
    vec_t r;
    r.valid = v;   r.rd = rd[RW-1:0]; r.wb = wb;   r.memrd = ld;
    r.rs1 = rs1[RW-1:0]; r.use1 = u1; r.rs2 = rs2[RW-1:0]; r.use2 = u2;
    r.flush = fl;  r.hold = ho;       r.exp_stall = es; r.exp_bubble = eb;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.valid; id_rd = v.rd; id_wb = v.wb; id_memrd = v.memrd;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use1 = v.use1; id_use2 = v.use2;
    flush = v.flush; hold = v.hold;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{rd: 0, wb: 0, ld: 0};
`ifdef HAZ_STATS_EN
    m_cnt = 0;
`endif
  endtask

  function automatic bit model_lu();
    int r;
    r = pipe[0].rd;
    if (!(pipe[0].ld && pipe[0].wb && r != 0 && id_valid)) return 0;
    return (id_use1 && int'(id_rs1) == r) || (id_use2 && int'(id_rs2) == r);
  endfunction

  // Compare every visible output with the model for the current cycle
  task automatic check_model(input string tag);
    bit lu;
    lu = model_lu();
    chk({tag, " stall"},   int'(stall),   int'(hold || (!flush && lu)));
    chk({tag, " bubble"},  int'(bubble),  int'(!hold && (flush || lu)));
    chk({tag, " idexrd"},  int'(idexrd),  pipe[0].rd);
    chk({tag, " exmemrd"}, int'(exmemrd), pipe[1].rd);
    chk({tag, " exmemwb"}, int'(exmemwb), int'(pipe[1].wb));
    chk({tag, " memwbrd"}, int'(memwbrd), pipe[2].rd);
    chk({tag, " memwb"},   int'(memwb),   int'(pipe[2].wb));
`ifdef HAZ_STATS_EN
    chk({tag, " stallcnt"}, int'(stallcnt), m_cnt);
`endif
  endtask

  // Move the model one clock edge using the inputs currently applied,
  // then let the DUT take the same edge
  task automatic advance();
    bit lu;
    lu = model_lu();
    if (!hold) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (flush || lu) begin
        pipe[0] = '{rd: 0, wb: 0, ld: 0};
      end else if (id_valid) begin
        pipe[0].rd = int'(id_rd);
        pipe[0].wb = id_wb && (id_rd != 0);
        pipe[0].ld = id_memrd;
      end else begin
        pipe[0] = '{rd: 0, wb: 0, ld: 0};
      end
`ifdef HAZ_STATS_EN
      if (!flush && lu) m_cnt++;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t tbl[15];

  initial begin
    rst = 1'b0;
    idle();
    // valid, rd, wb, ld, rs1, u1, rs2, u2, flush, hold, exp_stall, exp_bubble
    tbl[0]  = mk(1, 7, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0); // load x7 enters
    tbl[1]  = mk(1, 8, 1, 0,  0, 0, 7, 1, 0, 0, 1, 1); // consumer on rs2 -> LU
    tbl[2]  = mk(1, 8, 1, 0,  0, 0, 7, 1, 0, 0, 0, 0); // load in EX/MEM, forwarded
    tbl[3]  = mk(1, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0); // load to x0
    tbl[4]  = mk(1, 2, 1, 1,  0, 1, 0, 1, 0, 0, 0, 0); // reads x0: no hazard
    tbl[5]  = mk(1, 4, 1, 0,  2, 0, 3, 1, 0, 0, 0, 0); // rs1 matches but unused
    tbl[6]  = mk(1, 6, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0); // load x6
    tbl[7]  = mk(1, 9, 1, 0,  6, 1, 0, 0, 1, 0, 0, 1); // FLUSH beats LU
    tbl[8]  = mk(1, 5, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0); // load x5
    tbl[9]  = mk(1, 5, 1, 1,  5, 1, 0, 0, 0, 1, 1, 0); // HOLD beats LU
    tbl[10] = mk(1, 5, 1, 1,  5, 1, 0, 0, 0, 0, 1, 1); // LU after hold
    tbl[11] = mk(1, 5, 1, 1,  5, 1, 0, 0, 0, 0, 0, 0); // dependent load enters
    tbl[12] = mk(1, 1, 1, 0,  5, 1, 0, 0, 0, 0, 1, 1); // its own LU stall
    tbl[13] = mk(1, 1, 1, 0,  5, 1, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 3, 1, 0,  5, 1, 0, 0, 0, 0, 0, 0); // empty ID slot

    // Reset state
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("reset exmemwb", int'(exmemwb), 0);
    chk("reset memwbrd", int'(memwbrd), 0);
    chk("reset idexrd",  int'(idexrd),  0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("tbl%0d stall", i),  int'(stall),  int'(tbl[i].exp_stall));
      chk($sformatf("tbl%0d bubble", i), int'(bubble), int'(tbl[i].exp_bubble));
      check_model($sformatf("tbl%0d", i));
      advance();
    end

    // Plain flow latency: rd=5 non-load shows in EX/MEM after 2 edges, MEM/WB after 3
    do_reset();
    drive(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    advance();
    idle();
    chk("flow stall e1", int'(stall), 0);
    advance();
    chk("flow exmemrd e2", int'(exmemrd), 5);
    chk("flow exmemwb e2", int'(exmemwb), 1);
    chk("flow memwb e2",   int'(memwb),   0);
    advance();
    chk("flow memwbrd e3", int'(memwbrd), 5);
    chk("flow memwb e3",   int'(memwb),   1);
    chk("flow exmemwb e3", int'(exmemwb), 0);

    // HOLD for 3 cycles with rd=3/4/6 in flight
    do_reset();
    drive(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); advance();
    drive(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); advance();
    drive(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); advance();
    for (int c = 0; c < 3; c++) begin
      drive(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      #1;
      chk($sformatf("hold%0d stall", c),   int'(stall),   1);
      chk($sformatf("hold%0d bubble", c),  int'(bubble),  0);
      chk($sformatf("hold%0d memwbrd", c), int'(memwbrd), 3);
      chk($sformatf("hold%0d exmemrd", c), int'(exmemrd), 4);
      chk($sformatf("hold%0d idexrd", c),  int'(idexrd),  6);
      advance();
    end
    idle();
    #1;
    chk("hold rel stall", int'(stall), 0);
    advance();
    chk("hold rel1 memwbrd", int'(memwbrd), 4);
    chk("hold rel1 exmemrd", int'(exmemrd), 6);
    chk("hold rel1 idexrd",  int'(idexrd),  0);
    advance();
    chk("hold rel2 memwbrd", int'(memwbrd), 6);
    chk("hold rel2 exmemwb", int'(exmemwb), 0);

    // Reset asserted mid-stall: STALL drops in the same cycle
    do_reset();
    drive(mk(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)); advance();
    drive(mk(1, 2, 1, 0, 7, 1, 0, 0, 0, 0, 0, 0)); advance();
    drive(mk(1, 2, 1, 0, 2, 1, 0, 0, 0, 0, 0, 0));
    #1;
    chk("prerst exmemrd", int'(exmemrd), 7);
    drive(mk(1, 12, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)); advance();
    drive(mk(1, 3, 1, 0, 12, 1, 0, 0, 0, 0, 0, 0));
    #1;
    chk("midrst stall before", int'(stall), 1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst stall",   int'(stall),   0);
    chk("midrst bubble",  int'(bubble),  0);
    chk("midrst idexrd",  int'(idexrd),  0);
    chk("midrst exmemrd", int'(exmemrd), 0);
    chk("midrst memwbrd", int'(memwbrd), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      check_model($sformatf("postrst%0d", c));
      advance();
    end

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      id_valid = ($urandom_range(0, 7) != 0);
      id_rd    = RW'($urandom_range(0, 4));
      id_wb    = ($urandom_range(0, 3) != 0);
      id_memrd = ($urandom_range(0, 1) != 0);
      id_rs1   = RW'($urandom_range(0, 4));
      id_rs2   = RW'($urandom_range(0, 4));
      id_use1  = ($urandom_range(0, 3) != 0);
      id_use2  = ($urandom_range(0, 1) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      hold     = ($urandom_range(0, 7) == 0);
      #1;
      check_model($sformatf("rnd%0d", n));
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
